// File: rtl/lsu_pkg.sv
// Shared encodings and lane helpers for the load/store sequencer.
// Big-endian lane numbering: offset 0 is the most significant byte.
package lsu_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_BAD  = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    MERGE,
    RESP
  } state_t;

  localparam logic [31:0] LANE_BYTE = 32'h0000_00ff;
  localparam logic [31:0] LANE_HALF = 32'h0000_ffff;

  // Bit position of the addressed lane's LSB within the word.
  function automatic logic [4:0] lane_shift(
    input logic [1:0] size,
    input logic [1:0] off
  );
    if (size == SIZE_HALF)
      lane_shift = {~off[1], 4'b0000};
    else
      lane_shift = {~off, 3'b000};
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Big-endian lane extract for loads and lane merge for stores.
// Shared by the load path and the read-modify-write path.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        sgn,
  input  logic [31:0] wdata,
  output logic [31:0] load,
  output logic [31:0] merged
);

  logic [4:0]  sh;
  logic [15:0] lane;
  logic [31:0] mask;

  always_comb begin
    sh     = lane_shift(size, off);
    lane   = 16'(word >> sh);
    mask   = LANE_BYTE;
    load   = word;
    merged = wdata;
    case (size)
      SIZE_BYTE: begin
        mask   = LANE_BYTE;
        load   = {{24{sgn & lane[7]}}, lane[7:0]};
        merged = (word & ~(mask << sh))
               | ((wdata & mask) << sh);
      end
      SIZE_HALF: begin
        mask   = LANE_HALF;
        load   = {{16{sgn & lane[15]}}, lane};
        merged = (word & ~(mask << sh))
               | ((wdata & mask) << sh);
      end
      default: begin
        load   = word;
        merged = wdata;
      end
    endcase
  end

endmodule

// File: rtl/load_store_sequencer.sv
// Byte/half/word load-store sequencer for a word-wide memory.
// Sub-word stores go through a read-modify-write in MERGE.
module load_store_sequencer
  import lsu_pkg::*;
#(
  parameter int MEMORY_SIZE = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_write,
  input  logic [31:0] mem_rdata
);

  localparam logic [31:0] LAST_WORD =
    32'(MEMORY_SIZE - 4);

  state_t      state;
  logic [1:0]  off_q;
  logic [1:0]  size_q;
  logic        sgn_q;
  logic        write_q;
  logic [31:0] wdata_q;
  logic        bad;
  logic [31:0] lane_load;
  logic [31:0] lane_merged;

  assign req_ready = (state == IDLE);

  assign bad = (req_size == SIZE_BAD)
    || (req_size == SIZE_HALF && req_addr[0])
    || (req_size == SIZE_WORD && req_addr[1:0] != 2'b00)
    || ({req_addr[31:2], 2'b00} > LAST_WORD);

  lsu_byte_lane u_lane (
    .word   (mem_rdata),
    .off    (off_q),
    .size   (size_q),
    .sgn    (sgn_q),
    .wdata  (wdata_q),
    .load   (lane_load),
    .merged (lane_merged)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      off_q      <= '0;
      size_q     <= '0;
      sgn_q      <= 1'b0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_write  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            off_q   <= req_addr[1:0];
            size_q  <= req_size;
            sgn_q   <= req_signed;
            write_q <= req_write;
            wdata_q <= req_wdata;
            if (bad) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else begin
              state    <= ACCESS;
              mem_addr <= {req_addr[31:2], 2'b00};
              if (req_write && req_size == SIZE_WORD) begin
                mem_write <= 1'b1;
                mem_wdata <= req_wdata;
              end
            end
          end
        end
        ACCESS: begin
          if (write_q && size_q != SIZE_WORD) begin
            state     <= MERGE;
            mem_write <= 1'b1;
            mem_wdata <= lane_merged;
          end else begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_rdata <= write_q ? '0 : lane_load;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
          end
        end
        MERGE: begin
          state      <= RESP;
          resp_valid <= 1'b1;
          mem_write  <= 1'b0;
          mem_addr   <= '0;
          mem_wdata  <= '0;
        end
        RESP: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          resp_rdata <= '0;
          resp_err   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_sequencer.sv
// Directed bench for load_store_sequencer with a 64-byte memory.
// Expected values are hand-computed big-endian results.
module tb_load_store_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_write;
  logic [31:0] mem_rdata;

  logic [31:0] mem [16];

  int passed = 0;
  int total = 0;

  int          lat;
  logic [31:0] rd;
  logic [31:0] wa;
  logic [31:0] wd;
  logic        er;
  logic        sw;
  logic        extra;

  always #5 clk = ~clk;

  load_store_sequencer #(.MEMORY_SIZE(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_write  (mem_write),
    .mem_rdata  (mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[5:2]];

  always @(posedge clk)
    if (mem_write) mem[mem_addr[5:2]] <= mem_wdata;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h want %h",
                tag, obs, exp);
  endtask

  task automatic op(
    input logic        w,
    input logic [1:0]  sz,
    input logic        sg,
    input logic [31:0] a,
    input logic [31:0] d
  );
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = w;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = d;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 1;
    sw  = 1'b0;
    wa  = '0;
    wd  = '0;
    while (!resp_valid && lat < 10) begin
      if (mem_write) begin
        sw = 1'b1;
        wa = mem_addr;
        wd = mem_wdata;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    rd = resp_rdata;
    er = resp_err;
    @(posedge clk);
    #1;
    extra = resp_valid | ~req_ready;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int npulse;
    int c1;
    int c2;
    logic [31:0] r1;
    logic [31:0] r2;
    logic ready2;
    logic ready3;
    logic seen;

    for (int i = 0; i < 16; i++) mem[i] = '0;

    // Reset values
    #1;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_rvalid", 32'(resp_valid), 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_err", 32'(resp_err), 32'd0);
    check("rst_mwrite", 32'(mem_write), 32'd0);
    check("rst_maddr", mem_addr, 32'd0);
    check("rst_mwdata", mem_wdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Background word at addr 4 for error checks
    op(1'b1, 2'b10, 1'b0, 32'd4, 32'h1122_3344);
    check("st4_mem", mem[1], 32'h1122_3344);

    // Word store then word load at addr 8
    op(1'b1, 2'b10, 1'b0, 32'd8, 32'hDEAD_BEEF);
    check("stw_lat", 32'(lat), 32'd2);
    check("stw_wr", 32'(sw), 32'd1);
    check("stw_addr", wa, 32'd8);
    check("stw_data", wd, 32'hDEAD_BEEF);
    check("stw_err", 32'(er), 32'd0);
    check("stw_rdata", rd, 32'd0);
    check("stw_mem", mem[2], 32'hDEAD_BEEF);
    check("stw_after", 32'(extra), 32'd0);

    op(1'b0, 2'b10, 1'b0, 32'd8, 32'd0);
    check("ldw_lat", 32'(lat), 32'd2);
    check("ldw_data", rd, 32'hDEAD_BEEF);
    check("ldw_err", 32'(er), 32'd0);
    check("ldw_after", 32'(extra), 32'd0);

    // Sub-word loads
    op(1'b0, 2'b00, 1'b1, 32'd9, 32'd0);
    check("lbs9", rd, 32'hFFFF_FFAD);
    op(1'b0, 2'b00, 1'b0, 32'd9, 32'd0);
    check("lbu9", rd, 32'h0000_00AD);
    op(1'b0, 2'b01, 1'b1, 32'd10, 32'd0);
    check("lhs10", rd, 32'hFFFF_BEEF);
    op(1'b0, 2'b01, 1'b0, 32'd8, 32'd0);
    check("lhu8", rd, 32'h0000_DEAD);
    op(1'b0, 2'b00, 1'b1, 32'd11, 32'd0);
    check("lbs11", rd, 32'hFFFF_FFEF);

    // Byte store read-modify-write
    op(1'b1, 2'b00, 1'b0, 32'd10, 32'h0000_0055);
    check("sb_lat", 32'(lat), 32'd3);
    check("sb_wr", 32'(sw), 32'd1);
    check("sb_addr", wa, 32'd8);
    check("sb_data", wd, 32'hDEAD_55EF);
    check("sb_mem", mem[2], 32'hDEAD_55EF);
    op(1'b0, 2'b10, 1'b0, 32'd8, 32'd0);
    check("sb_reload", rd, 32'hDEAD_55EF);

    // Error cases
    op(1'b0, 2'b01, 1'b0, 32'd5, 32'd0);
    check("e_h5_lat", 32'(lat), 32'd1);
    check("e_h5_err", 32'(er), 32'd1);
    check("e_h5_wr", 32'(sw), 32'd0);
    check("e_h5_rdata", rd, 32'd0);
    op(1'b1, 2'b10, 1'b0, 32'd6, 32'hCAFE_F00D);
    check("e_w6_lat", 32'(lat), 32'd1);
    check("e_w6_err", 32'(er), 32'd1);
    check("e_w6_wr", 32'(sw), 32'd0);
    op(1'b0, 2'b11, 1'b0, 32'd0, 32'd0);
    check("e_sz_lat", 32'(lat), 32'd1);
    check("e_sz_err", 32'(er), 32'd1);
    op(1'b0, 2'b10, 1'b0, 32'd64, 32'd0);
    check("e_64_lat", 32'(lat), 32'd1);
    check("e_64_err", 32'(er), 32'd1);
    check("e_64_wr", 32'(sw), 32'd0);
    check("e_mem1", mem[1], 32'h1122_3344);
    check("e_mem2", mem[2], 32'hDEAD_55EF);
    op(1'b0, 2'b10, 1'b0, 32'd60, 32'd0);
    check("ok60_err", 32'(er), 32'd0);
    check("ok60_lat", 32'(lat), 32'd2);

    // Back-to-back with req_valid held high
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_size   = 2'b10;
    req_signed = 1'b0;
    req_addr   = 32'd8;
    @(posedge clk);
    #1;
    req_size = 2'b00;
    npulse = 0;
    c1 = 0;
    c2 = 0;
    r1 = '0;
    r2 = '0;
    ready2 = 1'b0;
    ready3 = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      if (resp_valid) begin
        npulse++;
        if (npulse == 1) begin
          c1 = i;
          r1 = resp_rdata;
        end else begin
          c2 = i;
          r2 = resp_rdata;
        end
      end
      if (i == 2) ready2 = req_ready;
      if (i == 3) begin
        ready3 = req_ready;
        req_valid = 1'b0;
      end
    end
    check("b2b_pulses", 32'(npulse), 32'd2);
    check("b2b_c1", 32'(c1), 32'd1);
    check("b2b_r1", r1, 32'hDEAD_55EF);
    check("b2b_ready2", 32'(ready2), 32'd1);
    check("b2b_ready3", 32'(ready3), 32'd0);
    check("b2b_c2", 32'(c2), 32'd4);
    check("b2b_r2", r2, 32'h0000_00DE);

    // Reset during MERGE of a byte store
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_size   = 2'b00;
    req_addr   = 32'd8;
    req_wdata  = 32'h0000_0077;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    check("mr_wr", 32'(mem_write), 32'd1);
    check("mr_data", mem_wdata, 32'h77AD_55EF);
    rst = 1'b1;
    #1;
    check("mr_rst_wr", 32'(mem_write), 32'd0);
    check("mr_rst_addr", mem_addr, 32'd0);
    check("mr_rst_wdata", mem_wdata, 32'd0);
    check("mr_rst_ready", 32'(req_ready), 32'd1);
    check("mr_rst_rv", 32'(resp_valid), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (resp_valid || mem_write) seen = 1'b1;
    end
    check("mr_no_resp", 32'(seen), 32'd0);
    check("mr_mem", mem[2], 32'hDEAD_55EF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
